uart_baud_tx: RTL and testbench

- Self-contained UART transmit path: an integer baud-rate generator plus a frame serializer (start, data LSB-first, optional parity, stop).
- Sits between board-level control logic and the physical TX pin, e.g. the button-state link to the ESP32: 100 MHz clock, 115200 baud, 8N1.
- Also exports baud and oversampled tick strobes for sibling receive logic.

---
 rtl/uart_baud_tx.sv | 168 ++++++++++++++++
 tb/tb_uart_baud_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_tx.sv
// UART transmit path: integer baud and oversample tick generators feeding a
// start / data (LSB first) / optional parity / stop frame serializer.
// The serial line is driven from a register so it never glitches.
module uart_baud_tx #(
    parameter int   CLK_FREQ_HZ  = 100_000_000,
    parameter int   BAUD_RATE    = 115200,
    parameter int   OVERSAMPLING = 16,
    parameter int   DATA_BITS    = 8,
    parameter logic PARITY_EN    = 1'b0,
    parameter logic PARITY_TYPE  = 1'b0,
    parameter int   STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 tx_start,
    input  logic                 cts,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tick,
    output logic                 tick_16x
);

    // Divisors rounded to the nearest integer at elaboration time.
    localparam int DIV   = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int DIV16 = (CLK_FREQ_HZ + (BAUD_RATE * OVERSAMPLING) / 2)
                           / (BAUD_RATE * OVERSAMPLING);
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW16  = (DIV16 > 1) ? $clog2(DIV16) : 1;
    localparam int IDXW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0]   DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW16-1:0] DIV16_LAST = CW16'(DIV16 - 1);
    localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(DATA_BITS - 1);
    localparam logic            STOP_LAST  = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         baud_cnt_q, baud_cnt_d;
    logic [CW16-1:0]       os_cnt_q, os_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic                  stop_q, stop_d;
    logic                  par_q, par_d;
    logic                  tx_out_q, tx_out_d;
    logic                  done_q, done_d;
    logic                  baud_clr;

    // Strobes decode straight off the counters; a disabled generator never ticks.
    assign tick     = enable && (baud_cnt_q == DIV_LAST);
    assign tick_16x = enable && (os_cnt_q == DIV16_LAST);

    assign tx_out  = tx_out_q;
    assign tx_busy = (state_q != S_IDLE);
    assign tx_done = done_q;

    // Baud and oversample counters; accepting a frame realigns the baud phase.
    always_comb begin
        baud_cnt_d = baud_cnt_q + CW'(1);
        os_cnt_d   = os_cnt_q + CW16'(1);
        if (!enable || baud_clr || tick) begin
            baud_cnt_d = '0;
        end
        if (!enable || tick_16x) begin
            os_cnt_d = '0;
        end
    end

    // Frame sequencing and the value the line will carry next cycle.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        par_d    = par_q;
        baud_clr = 1'b0;
        done_d   = 1'b0;
        tx_out_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (tx_start && cts) begin
                    shift_d  = tx_data;
                    par_d    = (^tx_data) ^ PARITY_TYPE;
                    idx_d    = '0;
                    stop_d   = 1'b0;
                    baud_clr = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        unique case (state_d)
            S_START:  tx_out_d = 1'b0;
            S_DATA:   tx_out_d = shift_d[0];
            S_PARITY: tx_out_d = par_d;
            default:  tx_out_d = 1'b1;
        endcase
    end

    // Control state, counters and the registered line output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            os_cnt_q   <= '0;
            idx_q      <= '0;
            stop_q     <= 1'b0;
            tx_out_q   <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            os_cnt_q   <= os_cnt_d;
            idx_q      <= idx_d;
            stop_q     <= stop_d;
            tx_out_q   <= tx_out_d;
            done_q     <= done_d;
        end
    end

    // Payload and parity are only consumed after being loaded, so no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

endmodule

// File: tb/tb_uart_baud_tx.sv
// Bench for uart_baud_tx: three instances (8N1, 8E1, 8O1) share stimulus.
module tb_uart_baud_tx;

    localparam int BIT_T   = 868;
    localparam int FRAME_W = 9600;

    logic       clk = 1'b0;
    logic       rst_n, enable, tx_start, cts;
    logic [7:0] tx_data;

    logic tx_out0, tx_busy0, tx_done0, tick0, tick16_0;
    logic tx_out1, tx_busy1, tx_done1, tick1, tick16_1;
    logic tx_out2, tx_busy2, tx_done2, tick2, tick16_2;

    always #5 clk = ~clk;

    uart_baud_tx u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tx_start(tx_start),
        .cts(cts), .tx_data(tx_data), .tx_out(tx_out0), .tx_busy(tx_busy0),
        .tx_done(tx_done0), .tick(tick0), .tick_16x(tick16_0)
    );

    uart_baud_tx #(.PARITY_EN(1'b1), .PARITY_TYPE(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tx_start(tx_start),
        .cts(cts), .tx_data(tx_data), .tx_out(tx_out1), .tx_busy(tx_busy1),
        .tx_done(tx_done1), .tick(tick1), .tick_16x(tick16_1)
    );

    uart_baud_tx #(.PARITY_EN(1'b1), .PARITY_TYPE(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tx_start(tx_start),
        .cts(cts), .tx_data(tx_data), .tx_out(tx_out2), .tx_busy(tx_busy2),
        .tx_done(tx_done2), .tick(tick2), .tick_16x(tick16_2)
    );

    typedef struct {
        logic [10:0] b0;      // 8N1 line samples, index 0 = start bit
        logic [10:0] b1;      // 8E1
        logic [10:0] b2;      // 8O1
        int          busy0;
        int          dones0;
        int          done_idx0;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       cts;
        logic       accept;
        logic       par_even;
    } vec_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    function automatic exp_t make_exp(input logic [7:0] d, input logic acc,
                                      input logic par_even);
        exp_t e;
        if (acc) begin
            e.b0        = {2'b11, d, 1'b0};
            e.b1        = {1'b1, par_even, d, 1'b0};
            e.b2        = {1'b1, ~par_even, d, 1'b0};
            e.busy0     = 10 * BIT_T;
            e.dones0    = 1;
            e.done_idx0 = 10 * BIT_T;
        end else begin
            e.b0        = 11'h7FF;
            e.b1        = 11'h7FF;
            e.b2        = 11'h7FF;
            e.busy0     = 0;
            e.dones0    = 0;
            e.done_idx0 = -1;
        end
        return e;
    endfunction

    // Drive one start pulse, sample every line at mid-bit, then score.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic c,
                             input logic acc, input logic par_even,
                             input logic disturb);
        logic [10:0] g0, g1, g2;
        int          busy, dones, didx, k;
        exp_t        e;
        g0 = '1; g1 = '1; g2 = '1;
        busy = 0; dones = 0; didx = -1;
        @(negedge clk);
        tx_data  = d;
        cts      = c;
        tx_start = 1'b1;
        sb.push_back(make_exp(d, acc, par_even));
        @(negedge clk);
        tx_start = 1'b0;
        for (int i = 0; i < FRAME_W; i++) begin
            if (disturb && i == 2000) begin
                tx_data  = ~d;
                cts      = 1'b0;
                tx_start = 1'b1;
            end
            if (disturb && i == 2001) tx_start = 1'b0;
            if ((i % BIT_T) == BIT_T / 2 && i < 11 * BIT_T) begin
                k = i / BIT_T;
                g0[k] = tx_out0;
                g1[k] = tx_out1;
                g2[k] = tx_out2;
            end
            busy += int'(tx_busy0);
            if (tx_done0) begin
                dones++;
                didx = i;
            end
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_line_8n1"}, int'(g0), int'(e.b0));
            chk({tag, "_line_8e1"}, int'(g1), int'(e.b1));
            chk({tag, "_line_8o1"}, int'(g2), int'(e.b2));
            chk({tag, "_busy_cycles"}, busy, e.busy0);
            chk({tag, "_done_pulses"}, dones, e.dones0);
            chk({tag, "_done_index"}, didx, e.done_idx0);
        end
    endtask

    initial begin
        vec_t vecs[3];
        int   cnt, fall, rise, done_seen;

        vecs[0] = '{data: 8'h55, cts: 1'b1, accept: 1'b1, par_even: 1'b0};
        vecs[1] = '{data: 8'h07, cts: 1'b1, accept: 1'b1, par_even: 1'b1};
        vecs[2] = '{data: 8'h3C, cts: 1'b0, accept: 1'b0, par_even: 1'b0};

        rst_n    = 1'b0;
        enable   = 1'b1;
        tx_start = 1'b0;
        cts      = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx_out", int'(tx_out0), 1);
        chk("rst_busy", int'(tx_busy0 | tx_busy1 | tx_busy2), 0);
        chk("rst_done", int'(tx_done0), 0);
        chk("rst_tick", int'(tick0), 0);
        chk("rst_tick16", int'(tick16_0), 0);
        rst_n = 1'b1;

        // Tick strobes: period and width.
        cnt = 0;
        while (!tick0 && cnt < 2000) begin @(negedge clk); cnt++; end
        chk("tick_seen", int'(tick0), 1);
        chk("tick_par_duts", int'(tick1 & tick2), 1);
        @(negedge clk);
        chk("tick_width", int'(tick0), 0);
        cnt = 1;
        while (!tick0 && cnt < 2000) begin @(negedge clk); cnt++; end
        chk("tick_period", cnt, BIT_T);
        cnt = 0;
        while (!tick16_0 && cnt < 200) begin @(negedge clk); cnt++; end
        chk("tick16_seen", int'(tick16_0), 1);
        chk("tick16_par_duts", int'(tick16_1 & tick16_2), 1);
        @(negedge clk);
        chk("tick16_width", int'(tick16_0), 0);
        cnt = 1;
        while (!tick16_0 && cnt < 200) begin @(negedge clk); cnt++; end
        chk("tick16_period", cnt, 54);

        // Table-driven frames.
        for (int v = 0; v < 3; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].cts,
                      vecs[v].accept, vecs[v].par_even, 1'b0);
        end

        // Re-pulse with other data and drop cts mid-frame: original byte goes out.
        run_frame("busy_ignore", 8'hC6, 1'b1, 1'b1, 1'b0, 1'b1);

        // Held start: one idle cycle between frames, then reset mid data bit.
        @(negedge clk);
        tx_data  = 8'hF0;
        cts      = 1'b1;
        tx_start = 1'b1;
        fall = -1;
        rise = -1;
        for (int i = 0; i < 10 * BIT_T + 1 + 3 * BIT_T + BIT_T / 2; i++) begin
            @(negedge clk);
            if (fall < 0 && !tx_busy0) fall = i;
            else if (fall >= 0 && rise < 0 && tx_busy0) begin
                rise = i;
                tx_start = 1'b0;
            end
        end
        tx_start = 1'b0;
        chk("b2b_busy_fall", fall, 10 * BIT_T);
        chk("b2b_busy_rise", rise, 10 * BIT_T + 1);
        chk("pre_rst_line", int'(tx_out0), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_line", int'(tx_out0 & tx_out1 & tx_out2), 1);
        chk("mid_rst_busy", int'(tx_busy0 | tx_busy1 | tx_busy2), 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            done_seen += int'(tx_done0 | tx_done1 | tx_done2);
        end
        chk("mid_rst_no_done", done_seen, 0);
        rst_n = 1'b1;

        run_frame("after_rst", 8'hA3, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
